rx_unit_gen: RTL

Parametrised successor of the NI receive unit. It decodes NoC phits arriving from the router, sequences payload words into SPM lines 1, 2 or 4 words wide, writes the configuration bus, and pushes interrupt entries into the IRQ FIFO. New in this generation: a configurable address width, registered write outputs, lane masks for partial lines, detection of malformed packets with abort, and a saturating error counter.

---
 rtl/rx_unit_gen.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_unit_gen.sv
// rx_unit_gen: NoC receive unit. Decodes phits from the router, packs payload
// words into SPM lines (MSB lane first), writes the config bus and pushes IRQ
// FIFO entries. Malformed phits are counted in a saturating error counter.
module rx_unit_gen #(
  parameter int ADDR_W    = 14,
  parameter int SPM_WORDS = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [34:0]             pkt_in,
  input  logic                    err_clr,
  output logic [ADDR_W-1:0]       spm_addr,
  output logic [SPM_WORDS-1:0]    spm_en,
  output logic                    spm_wr,
  output logic [32*SPM_WORDS-1:0] spm_wdata,
  output logic [ADDR_W-1:0]       config_addr,
  output logic                    config_en,
  output logic                    config_wr,
  output logic [31:0]             config_wdata,
  output logic [ADDR_W-1:0]       irq_fifo_data,
  output logic                    irq_fifo_data_valid,
  output logic                    irq_fifo_irq_valid,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int LANE_W = (SPM_WORDS > 1) ? $clog2(SPM_WORDS) : 1;
  localparam int LINE_W = 32 * SPM_WORDS;

  typedef enum logic [1:0] {IDLE, DATA, CFG, IRQ} state_t;

  // Phit fields and classes
  logic        vld, sop, eop;
  logic [31:0] word;
  logic        is_hdr, is_pay, is_bad;

  assign vld    = pkt_in[34];
  assign sop    = pkt_in[33];
  assign eop    = pkt_in[32];
  assign word   = pkt_in[31:0];
  assign is_hdr = vld & sop & ~eop;
  assign is_pay = vld & ~sop;
  assign is_bad = vld & sop & eop;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic                irqf_q, irqf_d;
  // first_q: no payload seen yet since the header (eop here means empty packet)
  logic                first_q, first_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LINE_W-1:0]   line_q, line_d, line_wr;
  logic                err;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  logic [ADDR_W-1:0]    spm_addr_d, config_addr_d, irq_fifo_data_d;
  logic [SPM_WORDS-1:0] spm_en_d;
  logic                 spm_wr_d, config_en_d, config_wr_d;
  logic                 irq_fifo_data_valid_d, irq_fifo_irq_valid_d;
  logic [LINE_W-1:0]    spm_wdata_d;
  logic [31:0]          config_wdata_d;

  // Next-state decode: packet sequencing, line assembly and output strobes
  always_comb begin
    state_d               = state_q;
    addr_d                = addr_q;
    start_d               = start_q;
    irqf_d                = irqf_q;
    first_d               = first_q;
    lane_d                = lane_q;
    line_d                = line_q;
    line_wr               = line_q;
    err                   = 1'b0;
    spm_addr_d            = '0;
    spm_en_d              = '0;
    spm_wr_d              = 1'b0;
    spm_wdata_d           = '0;
    config_addr_d         = '0;
    config_en_d           = 1'b0;
    config_wr_d           = 1'b0;
    config_wdata_d        = '0;
    irq_fifo_data_d       = '0;
    irq_fifo_data_valid_d = 1'b0;
    irq_fifo_irq_valid_d  = 1'b0;

    if (is_hdr) begin
      // A header mid-packet aborts the old packet; its partial line is dropped.
      err     = (state_q != IDLE);
      addr_d  = word[16 +: ADDR_W];
      start_d = word[16 +: ADDR_W];
      irqf_d  = word[31] & ~word[30];
      first_d = 1'b1;
      lane_d  = '0;
      line_d  = '0;
      case (word[31:30])
        2'b01:   state_d = CFG;
        2'b11:   state_d = IRQ;
        default: state_d = DATA;
      endcase
    end else if (is_bad) begin
      err = 1'b1;
    end else if (is_pay) begin
      if (state_q == IDLE) begin
        err = 1'b1;
      end else begin
        first_d = 1'b0;
        if (eop) state_d = IDLE;
        if (!(first_q && eop)) begin
          case (state_q)
            DATA: begin
              for (int i = 0; i < SPM_WORDS; i++) begin
                if (i == SPM_WORDS - 1 - int'(lane_q)) line_wr[32*i +: 32] = word;
              end
              if (eop || lane_q == LANE_W'(SPM_WORDS - 1)) begin
                spm_wr_d    = 1'b1;
                spm_addr_d  = addr_q;
                spm_wdata_d = line_wr;
                for (int i = 0; i < SPM_WORDS; i++) begin
                  spm_en_d[i] = (i >= SPM_WORDS - 1 - int'(lane_q));
                end
                addr_d = addr_q + ADDR_W'(1);
                lane_d = '0;
                line_d = '0;
                if (eop && irqf_q) begin
                  irq_fifo_data_valid_d = 1'b1;
                  irq_fifo_data_d       = start_q;
                end
              end else begin
                line_d = line_wr;
                lane_d = lane_q + LANE_W'(1);
              end
            end
            CFG: begin
              config_en_d    = 1'b1;
              config_wr_d    = 1'b1;
              config_addr_d  = addr_q;
              config_wdata_d = word;
              addr_d         = addr_q + ADDR_W'(1);
            end
            IRQ: begin
              irq_fifo_irq_valid_d = 1'b1;
              irq_fifo_data_d      = word[ADDR_W-1:0];
            end
            default: ;
          endcase
        end
      end
    end

    // Clear wins over counting, but an error in the clear cycle still counts once
    if (err_clr)
      err_cnt_d = ERR_CNT_W'(err);
    else if (err && (err_cnt != '1))
      err_cnt_d = err_cnt + ERR_CNT_W'(1);
    else
      err_cnt_d = err_cnt;
  end

  // State and registered outputs; synchronous active-low reset clears everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q             <= IDLE;
      addr_q              <= '0;
      start_q             <= '0;
      irqf_q              <= 1'b0;
      first_q             <= 1'b0;
      lane_q              <= '0;
      line_q              <= '0;
      err_cnt             <= '0;
      spm_addr            <= '0;
      spm_en              <= '0;
      spm_wr              <= 1'b0;
      spm_wdata           <= '0;
      config_addr         <= '0;
      config_en           <= 1'b0;
      config_wr           <= 1'b0;
      config_wdata        <= '0;
      irq_fifo_data       <= '0;
      irq_fifo_data_valid <= 1'b0;
      irq_fifo_irq_valid  <= 1'b0;
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      start_q             <= start_d;
      irqf_q              <= irqf_d;
      first_q             <= first_d;
      lane_q              <= lane_d;
      line_q              <= line_d;
      err_cnt             <= err_cnt_d;
      spm_addr            <= spm_addr_d;
      spm_en              <= spm_en_d;
      spm_wr              <= spm_wr_d;
      spm_wdata           <= spm_wdata_d;
      config_addr         <= config_addr_d;
      config_en           <= config_en_d;
      config_wr           <= config_wr_d;
      config_wdata        <= config_wdata_d;
      irq_fifo_data       <= irq_fifo_data_d;
      irq_fifo_data_valid <= irq_fifo_data_valid_d;
      irq_fifo_irq_valid  <= irq_fifo_irq_valid_d;
    end
  end

endmodule
